// File: rtl/fir_out_serializer.sv
// Serial transmitter for FIR output samples: a small FIFO feeds an MSB-first
// shifter that holds each bit for CLK_DIV clocks and flags each word's MSB with frame_sync.
module fir_out_serializer #(
  parameter int WIDTH_data = 24,
  parameter int DEPTH      = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WIDTH_data-1:0] d_in,
  input  logic                         d_valid,
  output logic                         ser_out,
  output logic                         frame_sync,
  output logic                         ser_active,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH_data > 1) ? $clog2(WIDTH_data) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(WIDTH_data - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [WIDTH_data-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [WIDTH_data-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic                  ser_out_q, ser_out_d, frame_sync_q, frame_sync_d;
  logic                  ser_active_q, ser_active_d, overflow_q, overflow_d;
  logic                  full, empty, div_end, word_end, pop, push;

  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    div_end  = (div_cnt_q == DIV_LAST);
    word_end = (state_q == SHIFT) && div_end && (bit_cnt_q == '0);
    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    pop      = !empty && ((state_q == IDLE) || word_end);
    push     = d_valid && (!full || pop);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d   = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (pop) begin
      state_d   = SHIFT;
      shift_d   = mem_q[rd_ptr_q];
      bit_cnt_d = BIT_TOP;
      div_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      if (!div_end) begin
        div_cnt_d = div_cnt_q + DW'(1);
      end else if (bit_cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        shift_d   = {shift_q[WIDTH_data-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - BW'(1);
        div_cnt_d = '0;
      end
    end
    // Outputs are registered from next-state values so they line up with the shifter.
    ser_active_d = (state_d == SHIFT);
    ser_out_d    = ser_active_d && shift_d[WIDTH_data-1];
    frame_sync_d = ser_active_d && (bit_cnt_d == BIT_TOP);
    overflow_d   = d_valid && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= d_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      ser_out_q    <= 1'b0;
      frame_sync_q <= 1'b0;
      ser_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      ser_out_q    <= ser_out_d;
      frame_sync_q <= frame_sync_d;
      ser_active_q <= ser_active_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign frame_sync = frame_sync_q;
  assign ser_active = ser_active_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_fir_out_serializer.sv
// Bench for fir_out_serializer: expected words queued at issue, a negedge monitor
// deserializes the line and checks framing; directed timing checks in the stimulus.
module tb_fir_out_serializer;
  localparam int W  = 24;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  d_in = '0, d1_in = '0;
  logic          d_valid = 1'b0, d1_valid = 1'b0;
  logic          ser_out, frame_sync, ser_active, overflow;
  logic [2:0]    fifo_level;
  logic          s1_out, s1_fs, s1_act, s1_ovf;
  logic [2:0]    s1_lvl;

  int pass_n = 0, total_n = 0;
  logic [W-1:0] exp_q[$];

  fir_out_serializer #(.WIDTH_data(W), .DEPTH(4), .CLK_DIV(CD)) u0 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .ser_out(ser_out),
    .frame_sync(frame_sync), .ser_active(ser_active), .overflow(overflow),
    .fifo_level(fifo_level));

  fir_out_serializer #(.WIDTH_data(W), .DEPTH(4), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .d_in(d1_in), .d_valid(d1_valid), .ser_out(s1_out),
    .frame_sync(s1_fs), .ser_active(s1_act), .overflow(s1_ovf),
    .fifo_level(s1_lvl));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok, input logic [31:0] got,
                     input logic [31:0] want);
    total_n++;
    if (ok) pass_n++;
    else $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: rebuild each word from the line and compare against the queue.
  int           ph = 0, bi = 0;
  logic [W-1:0] acc = '0;
  bit           fr_ok = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      ph = 0; bi = 0; fr_ok = 1'b1;
    end else if (ser_active) begin
      if (frame_sync !== (bi == 0)) fr_ok = 1'b0;
      if (ph == 0) acc = {acc[W-2:0], ser_out};
      else if (ser_out !== acc[0]) fr_ok = 1'b0;
      if (ph == CD - 1) begin
        ph = 0;
        if (bi == W - 1) begin
          bi = 0;
          if (exp_q.size() == 0) chk("word_unexpected", 1'b0, 32'(acc), 32'hx);
          else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("word", (acc == e) && fr_ok, 32'(acc), 32'(e));
          end
          fr_ok = 1'b1;
        end else bi++;
      end else ph++;
    end else begin
      chk("idle_line", {ser_out, frame_sync} == 2'b00 && bi == 0 && ph == 0,
          {30'd0, ser_out, frame_sync}, 32'd0);
    end
  end

  int act_n, fs_n, nrise;
  int rise_at[8];
  task automatic measure(input int bound);
    logic prev = 1'b0;
    act_n = 0; fs_n = 0; nrise = 0;
    for (int i = 0; i < bound; i++) begin
      if (!ser_active) break;
      act_n++;
      if (frame_sync) begin
        fs_n++;
        if (!prev && nrise < 8) begin rise_at[nrise] = i; nrise++; end
      end
      prev = frame_sync;
      tick();
      d_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!ser_active && fifo_level == 0) begin ok = 1'b1; break; end
      tick();
    end
    chk("wait_idle", ok, {29'd0, fifo_level}, 32'd0);
  endtask

  task automatic send(input logic [W-1:0] v);
    d_in = v; d_valid = 1'b1; exp_q.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] s [6];
    logic [W-1:0] bits;
    int fs1, act1;
    s[0] = 24'h111111; s[1] = 24'h2468AC; s[2] = 24'h7F00FF;
    s[3] = 24'h800000; s[4] = 24'h00FF01; s[5] = 24'hDEAD55;

    tick(); tick();
    chk("reset_u0", {ser_out, frame_sync, ser_active, overflow, fifo_level} == 0,
        {25'd0, ser_out, frame_sync, ser_active, overflow, fifo_level}, 32'd0);
    chk("reset_u1", {s1_out, s1_fs, s1_act, s1_ovf, s1_lvl} == 0,
        {25'd0, s1_out, s1_fs, s1_act, s1_ovf, s1_lvl}, 32'd0);
    rst = 1'b0;
    tick();

    // Single word 0x800001 from idle.
    send(24'h800001); tick(); d_valid = 1'b0;
    chk("lat_c1_idle", !ser_active, {31'd0, ser_active}, 32'd0);
    tick();
    chk("lat_c2", {ser_out, frame_sync, ser_active} == 3'b111,
        {29'd0, ser_out, frame_sync, ser_active}, 32'd7);
    measure(200);
    chk("single_active", act_n == 96, act_n, 96);
    chk("single_fs", fs_n == 4 && nrise == 1, fs_n, 4);
    chk("single_end_low", ser_out == 1'b0, {31'd0, ser_out}, 32'd0);
    wait_idle(50);

    // Three back-to-back words.
    send(24'h123456); tick();
    send(24'hFFFFFF); tick();
    send(24'h000000);
    measure(400);
    chk("b2b_active", act_n == 288, act_n, 288);
    chk("b2b_fs", fs_n == 12 && nrise == 3, fs_n, 12);
    chk("b2b_rise1", rise_at[1] == 96, rise_at[1], 96);
    chk("b2b_rise2", rise_at[2] == 192, rise_at[2], 192);
    wait_idle(50);

    // Six strobes: s5 dropped.
    for (int i = 0; i < 6; i++) begin
      d_in = s[i]; d_valid = 1'b1;
      if (i < 5) exp_q.push_back(s[i]);
      if (i == 5) chk("ovf_level4", fifo_level == 4 && !overflow, {28'd0, overflow, fifo_level}, 32'd4);
      tick();
    end
    d_valid = 1'b0;
    chk("ovf_pulse", overflow == 1'b1 && fifo_level == 4, {28'd0, overflow, fifo_level}, 32'hC);
    tick();
    chk("ovf_one_cycle", overflow == 1'b0, {31'd0, overflow}, 32'd0);
    wait_idle(700);

    // Full FIFO with a push on the exact word-end edge.
    for (int i = 0; i < 5; i++) begin send(s[i]); tick(); end
    d_valid = 1'b0;
    chk("full_level", fifo_level == 4, {29'd0, fifo_level}, 32'd4);
    repeat (92) tick();
    send(s[5]); tick(); d_valid = 1'b0;
    chk("push_on_pop", overflow == 1'b0 && fifo_level == 4 && frame_sync,
        {27'd0, frame_sync, overflow, fifo_level}, 32'h14);
    wait_idle(800);

    // Reset mid-word discards it.
    send(24'hA5A5A5); tick(); d_valid = 1'b0;
    repeat (50) tick();
    chk("pre_rst_active", ser_active == 1'b1, {31'd0, ser_active}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_outputs", {ser_out, frame_sync, ser_active, overflow, fifo_level} == 0,
        {25'd0, ser_out, frame_sync, ser_active, overflow, fifo_level}, 32'd0);
    exp_q.delete();
    tick(); rst = 1'b0; tick();
    chk("post_rst_idle", !ser_active && fifo_level == 0, {28'd0, ser_active, fifo_level}, 32'd0);
    send(24'h000001); tick(); d_valid = 1'b0; tick();
    chk("post_rst_c2", {ser_out, frame_sync, ser_active} == 3'b011,
        {29'd0, ser_out, frame_sync, ser_active}, 32'd3);
    measure(200);
    chk("post_rst_active", act_n == 96 && fs_n == 4, act_n, 96);
    wait_idle(50);

    // CLK_DIV=1 instance.
    d1_in = 24'hC00000; d1_valid = 1'b1; tick(); d1_valid = 1'b0; tick();
    bits = '0; fs1 = 0; act1 = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < W) bits = {bits[W-2:0], s1_out};
      if (s1_fs) begin
        fs1++;
        chk("div1_fs_pos", i == 0, i, 0);
      end
      if (s1_act) act1++;
      tick();
    end
    chk("div1_bits", bits == 24'hC00000, 32'(bits), 32'hC00000);
    chk("div1_fs_count", fs1 == 1, fs1, 1);
    chk("div1_active", act1 == 24, act1, 24);

    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/fir_out_serializer.md
Name: fir_out_serializer

Overview:
- Output-side transmitter for the FIR datapath: takes parallel signed filter results and shifts them out MSB-first on a single-bit serial line with a frame-sync strobe.
- A small FIFO decouples the filter's one-sample-per-strobe output from the slower serial transmission.
- Sits after the final accumulator/output register stage. It is the transmit counterpart of the serial sample receiver that feeds the filter input.

Parameters:
- WIDTH_data, 24, sample width in bits (signed two's complement, sent unmodified).
- DEPTH, 4, FIFO depth in samples; power of two, >= 2.
- CLK_DIV, 4, clk cycles per serial bit; >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  WIDTH_data  signed filter output sample.
- d_valid  input  1  d_in valid this cycle (single-cycle strobe, no backpressure).
- ser_out  output  1  serial data, MSB first, registered.
- frame_sync  output  1  high for the full bit period of each word's MSB, registered.
- ser_active  output  1  high while in SHIFT state.
- overflow  output  1  one-cycle pulse when a sample is dropped (FIFO full).
- fifo_level  output  $clog2(DEPTH+1)  current number of FIFO entries.

Behaviour:
- Reset (async assert, sync release):
  - ser_out=0, frame_sync=0, ser_active=0, overflow=0, fifo_level=0.
  - FIFO pointers cleared and state=IDLE.
  - An in-flight word is discarded. No partial word resumes after reset.
- FIFO write: d_valid && (!full || pop_this_cycle) writes d_in at the tail. A pop and a push in the same cycle are both honoured, and level is unchanged.
- Overflow: d_valid && full && !pop_this_cycle drops the sample. overflow=1 on the next cycle only; FIFO contents are unchanged.
- State machine: IDLE, SHIFT.
  - IDLE: ser_out=0, frame_sync=0. If FIFO is non-empty, pop the head into shift_reg, set bit_cnt=WIDTH_data-1 and div_cnt=0, and go to SHIFT.
  - SHIFT: ser_out=shift_reg[MSB]. Each bit is held exactly CLK_DIV cycles.
    - div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1, shift left one place and decrement bit_cnt.
    - frame_sync=1 while bit_cnt==WIDTH_data-1.
  - End of word (last bit, div_cnt==CLK_DIV-1):
    - If FIFO is non-empty, pop and load the next word in the same edge. Words go back-to-back with no idle gap; frame_sync rises immediately.
    - Otherwise go to IDLE.
- Latency: a d_valid at cycle 0 into an empty FIFO in IDLE gives ser_out=MSB and frame_sync=1 from cycle 2 (write at edge 0, pop/load at edge 1, registered outputs visible after edge 1).
- Word duration: exactly WIDTH_data*CLK_DIV cycles.
- A d_valid arriving during SHIFT never disturbs the word being transmitted.
- fifo_level reflects the post-edge count and never exceeds DEPTH.
- Pointer wrap-around is modulo DEPTH. Full/empty are derived with an extra pointer bit or the level counter, never ambiguous.

Test Plan (WIDTH_data=24, DEPTH=4, CLK_DIV=4 unless noted):
- Single sample 0x800001, idle → from cycle 2: ser_out=1 for 4 cycles, 0 for 88 cycles, 1 for 4 cycles. frame_sync=1 for the first 4 cycles only. ser_active high for 96 cycles, then IDLE with ser_out=0.
- Three samples 0x123456, 0xFFFFFF, 0x000000 on cycles 0,1,2 → 288 contiguous SHIFT cycles with no gap. frame_sync pulses (4 cycles wide) start at cycles 2, 98, 194. Bit streams match the samples MSB-first.
- Six d_valid on cycles 0..5 while idle → s0 transmitting, fifo_level=4 after edge 4. s5 dropped and overflow=1 on cycle 6 only. Later transmitted order is s1..s4.
- FIFO full and d_valid on the exact cycle a word ends with a pop → sample accepted, overflow stays 0, fifo_level stays 4.
- Assert rst for 1 cycle mid-word (bit 10 of 0xA5A5A5), then send 0x000001 → all outputs 0 immediately on rst with fifo_level=0. The next frame carries only 0x000001 with correct framing.
- CLK_DIV=1, sample 0xC00000 → 24-cycle word: ser_out=1,1 then 22 zeros; frame_sync high for exactly 1 cycle.
